// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared types and constants for the clock period meter
//
// Contents:
//   meter_state_t  : measurement FSM states (IDLE, ARM, RUN)
//   CNT_W_DEFAULT  : default width of the period counter and result
package clk_meter_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer followed by a both-edge detector
//
// Ports:
//   clk     : destination clock, rising edge
//   reset   : asynchronous, active-low reset
//   d_i     : asynchronous level input
//   event_o : one-cycle pulse on every transition of the synchronized level
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic event_o
);

    // Synchronizer chain: nothing but flops between the stages.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic                                         hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    // History always tracks the synchronized level, independent of any
    // consumer state, so re-enabling downstream logic never sees a stale edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign event_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures clk cycles between heartbeat toggles
//
// Ports:
//   clk       : measured/system clock, rising edge
//   reset     : asynchronous, active-low reset
//   enable_i  : measurement enable
//   tick_i    : heartbeat toggle from an asynchronous reference domain
//   clear_i   : clears the sticky overrun flag
//   period_o  : clk cycles between two consecutive tick_i transitions
//   sat_o     : period_o saturated
//   valid_o   : result available
//   ready_i   : consumer accepts result
//   overrun_o : sticky, a result was dropped
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             tick_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] period_o,
    output logic             sat_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    meter_state_t     state_q;
    meter_state_t     state_d;
    logic             tick_evt;
    logic             arm_evt;
    logic             run_evt;
    logic             counting;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat_q;
    logic [CNT_W-1:0] period_q;
    logic             sat_q;
    logic             valid_q;
    logic             overrun_q;
    logic             transfer;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk     (clk),
        .reset   (reset),
        .d_i     (tick_i),
        .event_o (tick_evt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: dropping enable returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  if (tick_evt) state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: the first event only arms, later events close a period
    always_comb begin
        arm_evt  = 1'b0;
        run_evt  = 1'b0;
        counting = 1'b0;
        case (state_q)
            ST_ARM: arm_evt = enable_i & tick_evt;
            ST_RUN: begin
                run_evt  = enable_i & tick_evt;
                counting = enable_i;
            end
            default: ;
        endcase
    end

    // Period counter. Reloading to 1 on an event makes the pre-update value
    // at the next event equal to the distance between the two events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            cnt_sat_q <= 1'b0;
        end else if (!enable_i) begin
            cnt_q     <= '0;
            cnt_sat_q <= 1'b0;
        end else if (arm_evt || run_evt) begin
            cnt_q     <= CNT_ONE;
            cnt_sat_q <= 1'b0;
        end else if (counting) begin
            if (cnt_q == CNT_MAX) begin
                cnt_sat_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign transfer = valid_q & ready_i;

    // Result holding register: a new result may replace the held one only if
    // the slot is empty or being emptied in this very cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q  <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (run_evt && (!valid_q || ready_i)) begin
                period_q <= cnt_q;
                sat_q    <= cnt_sat_q;
                valid_q  <= 1'b1;
            end else if (transfer) begin
                valid_q <= 1'b0;
            end

            if (run_evt && valid_q && !ready_i) begin
                overrun_q <= 1'b1;
            end else if (clear_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign period_o  = period_q;
    assign sat_o     = sat_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - directed self-checking bench for clk_period_meter
module tb_clk_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_i;
    logic        tick_i;
    logic        clear_i;
    logic        ready_i;

    logic [31:0] period32;
    logic        sat32;
    logic        valid32;
    logic        ovr32;
    logic [3:0]  period4;
    logic        sat4;
    logic        valid4;
    logic        ovr4;

    int          checks = 0;
    int          errors = 0;

    logic        got32;
    logic [31:0] gp32;
    logic        gs32;
    logic        got4;
    logic [3:0]  gp4;
    logic        gs4;
    logic        seen;

    always #5 clk = ~clk;

    clk_period_meter #(
        .CNT_W       (32),
        .SYNC_STAGES (2)
    ) dut32 (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable_i),
        .tick_i    (tick_i),
        .clear_i   (clear_i),
        .period_o  (period32),
        .sat_o     (sat32),
        .valid_o   (valid32),
        .ready_i   (ready_i),
        .overrun_o (ovr32)
    );

    clk_period_meter #(
        .CNT_W       (4),
        .SYNC_STAGES (2)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable_i),
        .tick_i    (tick_i),
        .clear_i   (clear_i),
        .period_o  (period4),
        .sat_o     (sat4),
        .valid_o   (valid4),
        .ready_i   (ready_i),
        .overrun_o (ovr4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Toggle the heartbeat, then run p cycles, capturing the first result seen.
    task automatic tick_period(input int p);
        tick_i = ~tick_i;
        got32  = 1'b0;
        got4   = 1'b0;
        for (int i = 0; i < p; i++) begin
            step(1);
            if (!got32 && valid32) begin
                got32 = 1'b1;
                gp32  = period32;
                gs32  = sat32;
            end
            if (!got4 && valid4) begin
                got4 = 1'b1;
                gp4  = period4;
                gs4  = sat4;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        enable_i = 1'b0;
        tick_i   = 1'b0;
        clear_i  = 1'b0;
        ready_i  = 1'b1;
        step(3);
        check("rst_valid",   valid32,  0);
        check("rst_period",  period32, 0);
        check("rst_sat",     sat32,    0);
        check("rst_overrun", ovr32,    0);

        reset = 1'b1;
        step(2);
        enable_i = 1'b1;
        step(2);

        // steady 10-cycle heartbeat
        tick_period(10);
        check("arm_only_no_result", got32, 0);
        tick_period(10);
        check("p10_valid", got32, 1);
        check("p10_period", gp32, 10);
        check("p10_sat", gs32, 0);
        tick_period(10);
        check("p10b_period", gp32, 10);
        check("p10_w4_period", gp4, 10);
        check("p10_w4_sat", gs4, 0);

        // 20-cycle periods saturate the 4-bit instance
        tick_period(20);
        check("p10c_period", gp32, 10);
        tick_period(20);
        check("p20_period", gp32, 20);
        check("p20_sat", gs32, 0);
        check("sat1_w4_period", gp4, 15);
        check("sat1_w4_sat", gs4, 1);
        tick_period(8);
        check("p20b_period", gp32, 20);
        check("sat2_w4_period", gp4, 15);
        check("sat2_w4_sat", gs4, 1);

        // backpressure: first result held, second dropped
        ready_i = 1'b0;
        tick_period(9);
        check("hold_valid", valid32, 1);
        check("hold_period", period32, 8);
        check("hold_no_overrun", ovr32, 0);
        tick_period(8);
        check("ovr_valid", valid32, 1);
        check("ovr_period_kept", period32, 8);
        check("ovr_set", ovr32, 1);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        check("clear_overrun", ovr32, 0);
        check("clear_keeps_valid", valid32, 1);

        // transfer in the same cycle a new result loads
        tick_i = ~tick_i;
        step(2);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        check("swap_valid", valid32, 1);
        check("swap_period", period32, 9);
        check("swap_no_overrun", ovr32, 0);
        step(7);
        check("swap_held_period", period32, 9);
        ready_i = 1'b1;
        step(1);
        check("drain_valid", valid32, 0);

        // asynchronous reset mid-period
        tick_period(7);
        check("p11_period", gp32, 11);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", valid32, 0);
        check("mid_rst_period", period32, 0);
        check("mid_rst_sat", sat32, 0);
        check("mid_rst_overrun", ovr32, 0);
        step(2);
        reset = 1'b1;
        step(3);
        tick_period(10);
        check("post_rst_arm_only", got32, 0);
        tick_period(10);
        check("post_rst_valid", got32, 1);
        check("post_rst_period", gp32, 10);

        // enable dropped for 3 cycles between events
        tick_i = ~tick_i;
        step(3);
        check("pre_idle_valid", valid32, 1);
        check("pre_idle_period", period32, 10);
        step(1);
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("idle_no_valid", valid32, 0);
        end
        enable_i = 1'b1;
        step(3);
        tick_period(10);
        check("rearm_no_result", got32, 0);
        tick_period(10);
        check("rearm_period", gp32, 10);

        // tick_i high across reset release: spurious event only arms
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (valid32) seen = 1'b1;
        end
        check("spurious_no_result", seen, 0);
        tick_period(10);
        check("spurious_then_period", gp32, 10);
        check("spurious_then_valid", got32, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the period counter and result.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop depth of the tick_i synchronizer (legal range 2..4).
REQ-003 SHALL have port clk  input  1  measured/system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable_i  input  1  measurement enable, clk domain.
REQ-006 SHALL have port tick_i  input  1  heartbeat toggle from a free-running reference domain, asynchronous to clk.
REQ-007 SHALL have port clear_i  input  1  single-cycle clear of sticky flags.
REQ-008 SHALL have port period_o  output  CNT_W  clk cycles between two consecutive tick_i transitions.
REQ-009 SHALL have port sat_o  output  1  period_o saturated (qualifies period_o).
REQ-010 SHALL have port valid_o  output  1  result available.
REQ-011 SHALL have port ready_i  input  1  consumer accepts result.
REQ-012 SHALL have port overrun_o  output  1  sticky: a result was dropped.

Function
REQ-013 SHALL pass tick_i through SYNC_STAGES flops, then one history flop; event = synchronized XOR history (both edges count).
REQ-014 SHALL detect an event SYNC_STAGES+1 clk cycles after tick_i settles.
REQ-015 SHALL implement FSM states IDLE, ARM, RUN.
REQ-016 IDLE -> ARM when enable_i=1; ARM -> RUN on first event (counter loaded to 1, no capture); RUN stays RUN on events.
REQ-017 Any state -> IDLE in the cycle after enable_i=0; counter cleared to 0; pending valid_o/period_o unaffected.
REQ-018 In RUN, counter SHALL increment by 1 per cycle, saturating at 2^CNT_W-1 with internal sat flag set; no wrap-around.
REQ-019 On an event in RUN, the pre-update counter value SHALL be the result (events at cycles t0, t1 give t1-t0); counter reloads to 1, sat flag clears.
REQ-020 Result SHALL be offered one cycle after the event: period_o/sat_o loaded, valid_o=1.
REQ-021 valid_o/period_o/sat_o SHALL stay stable while valid_o=1 and ready_i=0; transfer occurs on valid_o&ready_i, valid_o drops next cycle unless a new result loads that same cycle.
REQ-022 New result while valid_o=1 and ready_i=0: new result dropped, held result kept, overrun_o set.
REQ-023 New result in the same cycle as a transfer: new result loads, valid_o stays 1, no overrun.
REQ-024 overrun_o SHALL clear on clear_i=1; if set and clear coincide, set wins.
REQ-025 Events in IDLE SHALL be ignored; the history flop SHALL still track so re-enable does not create a false event.

Reset
REQ-026 On reset=0, asynchronously: FSM=IDLE, counter=0, sync and history flops=0, period_o=0, sat_o=0, valid_o=0, overrun_o=0.
REQ-027 Reset mid-measurement SHALL discard the partial count; first event after release only arms (ARM->RUN) once enable_i=1.
REQ-028 If tick_i=1 at reset release, one spurious event SHALL occur and SHALL only arm, never produce a result.

Structure
REQ-029 Package clk_meter_pkg SHALL hold the FSM state enum and the CNT_W default constant.
REQ-030 Synchronizer plus edge detector SHALL be a sub-module named sync_edge_det (parameter SYNC_STAGES; ports clk, reset, d_i, event_o).
REQ-031 Synchronizer flops SHALL carry the team's async-register attribute; no other logic between them.

Verification
REQ-032 enable_i=1, tick_i toggles every 10 clk -> after arm, valid_o with period_o=10, sat_o=0 on every event.
REQ-033 CNT_W=4, tick_i toggles every 20 clk -> period_o=15, sat_o=1; next 20-cycle period again 15/1.
REQ-034 ready_i=0 held, tick_i every 8 clk -> first period_o=8 held stable, overrun_o=1 after second event; clear_i -> overrun_o=0.
REQ-035 ready_i=1 pulsed in the exact cycle a new result loads -> valid_o stays 1, new period_o visible, overrun_o=0.
REQ-036 reset=0 asserted mid-period (count 5 of 10) -> all outputs 0 immediately; after release first event arms only, next gives period_o=10.
REQ-037 enable_i dropped for 3 cycles between events -> no result during IDLE; re-arm on next event; subsequent period_o=10.
